// File: rtl/serial_magnitude_compare_ctrl_if.sv
// Handshake bundle for serial_magnitude_compare_ctrl: operand side (in_*, a, b),
// result side (out_*, flags) and the busy status.
interface serial_magnitude_compare_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic             a_less_b;
   logic             a_equal_b;
   logic             a_greater_b;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, busy, out_valid, a_less_b, a_equal_b, a_greater_b
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, busy, out_valid, a_less_b, a_equal_b, a_greater_b
   );
endinterface

// File: rtl/serial_magnitude_compare_ctrl.sv
// Digit-serial (2 bits/cycle, MSB first) magnitude comparator with valid/ready on both sides.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: stop on the first unequal digit instead of constant-time.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready=1
// RUN     | comparing one digit per cycle, busy=1
// DONE    | result presented, out_valid=1 until out_ready
module serial_magnitude_compare_ctrl #(
   parameter int WIDTH       = 16,
   parameter int SIGNED_MODE = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   serial_magnitude_compare_ctrl_if.slave bus
);

   localparam int N     = WIDTH / 2;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   a_r, a_r_nx;
   logic [WIDTH-1:0]   b_r, b_r_nx;
   logic [IDX_W-1:0]   idx, idx_nx;
   logic               lt_r, lt_nx;
   logic               gt_r, gt_nx;
   logic               hit_r, hit_nx;
   logic               flag_lt, flag_lt_nx;
   logic               flag_eq, flag_eq_nx;
   logic               flag_gt, flag_gt_nx;

   logic [1:0]         dig_a;
   logic [1:0]         dig_b;
   logic               dig_lt;
   logic               dig_gt;
   logic               new_lt;
   logic               new_gt;
   logic               new_hit;
   logic               last_digit;

   // Shared digit comparator; the top digit gets its MSB flipped in signed mode
   // so two's complement orders like offset binary.
   always_comb begin
      dig_a = a_r[{idx, 1'b0} +: 2];
      dig_b = b_r[{idx, 1'b0} +: 2];
      if ((SIGNED_MODE != 0) && (idx == IDX_TOP)) begin
         dig_a[1] = ~dig_a[1];
         dig_b[1] = ~dig_b[1];
      end
      dig_lt = (dig_a < dig_b);
      dig_gt = (dig_a > dig_b);
   end

   always_comb begin
      new_lt  = lt_r;
      new_gt  = gt_r;
      new_hit = hit_r;
      if (!hit_r && (dig_lt || dig_gt)) begin
         new_lt  = dig_lt;
         new_gt  = dig_gt;
         new_hit = 1'b1;
      end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      last_digit = (idx == '0) || new_hit;
`else
      last_digit = (idx == '0);
`endif
   end

   always_comb begin
      state_nx   = state;
      a_r_nx     = a_r;
      b_r_nx     = b_r;
      idx_nx     = idx;
      lt_nx      = lt_r;
      gt_nx      = gt_r;
      hit_nx     = hit_r;
      flag_lt_nx = flag_lt;
      flag_eq_nx = flag_eq;
      flag_gt_nx = flag_gt;

      unique case (state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_r_nx   = bus.a;
               b_r_nx   = bus.b;
               idx_nx   = IDX_TOP;
               lt_nx    = 1'b0;
               gt_nx    = 1'b0;
               hit_nx   = 1'b0;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            lt_nx  = new_lt;
            gt_nx  = new_gt;
            hit_nx = new_hit;
            if (last_digit) begin
               flag_lt_nx = new_lt;
               flag_gt_nx = new_gt;
               flag_eq_nx = ~new_hit;
               state_nx   = ST_DONE;
            end else begin
               // Once decided, later digits are still stepped but ignored.
               idx_nx = idx - IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               flag_lt_nx = 1'b0;
               flag_eq_nx = 1'b0;
               flag_gt_nx = 1'b0;
               idx_nx     = IDX_TOP;
               state_nx   = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         a_r     <= '0;
         b_r     <= '0;
         idx     <= IDX_TOP;
         lt_r    <= 1'b0;
         gt_r    <= 1'b0;
         hit_r   <= 1'b0;
         flag_lt <= 1'b0;
         flag_eq <= 1'b0;
         flag_gt <= 1'b0;
      end else begin
         state   <= state_nx;
         a_r     <= a_r_nx;
         b_r     <= b_r_nx;
         idx     <= idx_nx;
         lt_r    <= lt_nx;
         gt_r    <= gt_nx;
         hit_r   <= hit_nx;
         flag_lt <= flag_lt_nx;
         flag_eq <= flag_eq_nx;
         flag_gt <= flag_gt_nx;
      end
   end

   assign bus.in_ready    = (state == ST_IDLE);
   assign bus.busy        = (state == ST_RUN);
   assign bus.out_valid   = (state == ST_DONE);
   assign bus.a_less_b    = flag_lt;
   assign bus.a_equal_b   = flag_eq;
   assign bus.a_greater_b = flag_gt;

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Directed bench: one unsigned and one signed instance driven in lockstep, WIDTH=16.
module tb_serial_magnitude_compare_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_magnitude_compare_ctrl_if #(.WIDTH(16)) ifu ();
   serial_magnitude_compare_ctrl_if #(.WIDTH(16)) ifs ();

   serial_magnitude_compare_ctrl #(.WIDTH(16), .SIGNED_MODE(0)) dut_u (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifu.slave)
   );

   serial_magnitude_compare_ctrl #(.WIDTH(16), .SIGNED_MODE(1)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifs.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags_u();
      return {ifu.a_less_b, ifu.a_equal_b, ifu.a_greater_b};
   endfunction

   function automatic logic [2:0] flags_s();
      return {ifs.a_less_b, ifs.a_equal_b, ifs.a_greater_b};
   endfunction

   task automatic drive(input logic v, input logic [15:0] va, input logic [15:0] vb);
      ifu.in_valid = v; ifu.a = va; ifu.b = vb;
      ifs.in_valid = v; ifs.a = va; ifs.b = vb;
   endtask

   task automatic set_out_ready(input logic r);
      ifu.out_ready = r;
      ifs.out_ready = r;
   endtask

   // Expected latency: k+1 with early exit (k = first differing digit from MSB), else N+1.
   function automatic int exp_lat(input int k);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      return k + 1;
`else
      return 9;
`endif
   endfunction

   // Flags packed as {lt, eq, gt}.
   task automatic run_cmp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input int lat_exp, input logic [2:0] fu, input logic [2:0] fs);
      int lat;
      @(posedge clk); #1;
      drive(1'b1, va, vb);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 16'h0);
      chk({tag, "_busy"}, {31'd0, ifu.busy}, 32'd1);
      lat = 1;
      while (!ifu.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, lat_exp);
      chk({tag, "_ov_s"}, {31'd0, ifs.out_valid}, 32'd1);
      chk({tag, "_flags_u"}, {29'd0, flags_u()}, {29'd0, fu});
      chk({tag, "_flags_s"}, {29'd0, flags_s()}, {29'd0, fs});
      @(posedge clk); #1;
      chk({tag, "_idle"}, {29'd0, ifu.in_ready, ifu.out_valid, ifs.out_valid}, 32'b100);
      chk({tag, "_clr"}, {26'd0, flags_u(), flags_s()}, 32'd0);
   endtask

   initial begin
      drive(1'b0, 16'h0, 16'h0);
      set_out_ready(1'b1);

      // Reset held 2 cycles
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state_u", {28'd0, ifu.in_ready, ifu.busy, ifu.out_valid, 1'b0}, 32'b1000);
      chk("rst_state_s", {28'd0, ifs.in_ready, ifs.busy, ifs.out_valid, 1'b0}, 32'b1000);
      chk("rst_flags", {26'd0, flags_u(), flags_s()}, 32'd0);
      rst_n = 1'b1;

      run_cmp("eq_1234",   16'h1234, 16'h1234, 9,          3'b010, 3'b010);
      run_cmp("msb_8000",  16'h8000, 16'h7FFF, exp_lat(1), 3'b001, 3'b100);
      run_cmp("lsd_0001",  16'h0001, 16'h0002, 9,          3'b100, 3'b100);
      run_cmp("ffff_0001", 16'hFFFF, 16'h0001, exp_lat(1), 3'b001, 3'b100);
      run_cmp("mid_1240",  16'h1240, 16'h1250, exp_lat(6), 3'b100, 3'b100);
      run_cmp("eq_zero",   16'h0000, 16'h0000, 9,          3'b010, 3'b010);

      // Backpressure: hold result 5 cycles while new operands are offered
      begin
         int lat;
         set_out_ready(1'b0);
         @(posedge clk); #1;
         drive(1'b1, 16'h0003, 16'h0001);
         @(posedge clk); #1;
         drive(1'b0, 16'h0, 16'h0);
         lat = 1;
         while (!ifu.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("bp_lat", lat, 9);
         for (int c = 0; c < 5; c++) begin
            drive(c[0] ? 1'b0 : 1'b1, 16'h0000, 16'hFFFF);
            @(posedge clk); #1;
            chk("bp_hold", {26'd0, ifu.out_valid, ifu.in_ready, ifs.out_valid, ifs.in_ready,
                            ifu.busy, ifs.busy}, 32'b101000);
            chk("bp_flags", {26'd0, flags_u(), flags_s()}, 32'b001001);
         end
         drive(1'b0, 16'h0, 16'h0);
         set_out_ready(1'b1);
         @(posedge clk); #1;
         chk("bp_release", {29'd0, ifu.in_ready, ifu.out_valid, ifs.out_valid}, 32'b100);
      end

      // Reset during cycle 4 of RUN discards the compare
      begin
         @(posedge clk); #1;
         drive(1'b1, 16'h0001, 16'h0002);
         @(posedge clk); #1;
         drive(1'b0, 16'h0, 16'h0);
         repeat (3) @(posedge clk);
         #1;
         chk("mid_run_busy", {31'd0, ifu.busy}, 32'd1);
         rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         chk("rst_run_state", {28'd0, ifu.in_ready, ifu.busy, ifu.out_valid, ifs.out_valid}, 32'b1000);
         chk("rst_run_flags", {26'd0, flags_u(), flags_s()}, 32'd0);
         for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk("rst_no_output", {30'd0, ifu.out_valid, ifs.out_valid}, 32'd0);
         end
      end

      run_cmp("post_rst",  16'h7FFF, 16'h8000, exp_lat(1), 3'b100, 3'b001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
